game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start (1..3).
REQ-002 Parameter BRICK_TOTAL, default 40: bricks per level (1..255).
REQ-003 Parameter SERVE_DELAY, default 60: frame ticks spent in SERVE before play (1..255).
REQ-004 Parameter SCORE_W, default 16: score width.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_btn  in  1  one-cycle pulse, new game / return to idle.
REQ-008 pause_btn  in  1  one-cycle pulse, pause toggle.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame.
REQ-010 fall_down, strike_brick, strike_board  in  1 each  one-cycle collision pulses.
REQ-011 game_status  out  2  00 Idle, 01 Start (SERVE or PLAY), 10 Pause, 11 Over.
REQ-012 ball_step  out  1  one-cycle ball-advance enable.
REQ-013 ball_reload  out  1  one-cycle pulse: re-centre ball on paddle.
REQ-014 score  out  SCORE_W  current score; lives  out  2; bricks_left  out  8.
REQ-015 win  out  1  high in OVER when all bricks cleared.
REQ-016 speed_lvl  out  2  ball speed level.

Function
REQ-017 Internal FSM states IDLE, SERVE, PLAY, PAUSE, OVER; all outputs registered, input effect visible one cycle after the input cycle.
REQ-018 IDLE: start_btn -> SERVE; same edge load lives=LIVES_INIT, score=0, bricks_left=BRICK_TOTAL, win=0, speed_lvl=0; ball_reload high for the first SERVE cycle.
REQ-019 SERVE: 8-bit counter cleared on entry, incremented per frame_tick; at SERVE_DELAY-th tick -> PLAY; collisions, pause_btn, start_btn ignored.
REQ-020 PLAY: ball_step high exactly one cycle after each frame_tick sampled in PLAY; never high in other states.
REQ-021 PLAY event priority per cycle: fall_down > strike_brick > strike_board; lower-priority pulses in same cycle discarded.
REQ-022 fall_down: lives -= 1; lives was 1 -> OVER, win=0; else -> SERVE with ball_reload pulse.
REQ-023 strike_brick: score += 10, bricks_left -= 1; bricks_left was 1 -> OVER, win=1.
REQ-024 strike_board: score += 1.
REQ-025 Score addition saturates at 2^SCORE_W-1; no wrap.
REQ-026 pause_btn: PLAY -> PAUSE, PAUSE -> PLAY; collisions and frame_tick ignored in PAUSE; counters frozen.
REQ-027 pause_btn takes precedence over a collision in the same PLAY cycle (collision discarded).
REQ-028 OVER: score, lives, bricks_left, win held; start_btn -> IDLE; all else ignored.
REQ-029 start_btn ignored in SERVE, PLAY, PAUSE.

Reset
REQ-030 rst high at any clock edge, any state: state=IDLE, game_status=00, score=0, lives=0, bricks_left=0, win=0, speed_lvl=0, ball_step=0, ball_reload=0, serve counter=0; rst overrides all inputs same edge.

Configuration
REQ-031 Macro GAME_SPEEDUP_EN defined: speed_lvl increments (saturating at 3) on each strike_brick that brings bricks destroyed to a multiple of 8; cleared on game start.
REQ-032 GAME_SPEEDUP_EN undefined: speed_lvl constant 0, no speed-up logic synthesised.

Verification
REQ-033 SERVE_DELAY=2: rst, start_btn, two frame_ticks -> ball_reload 1 cycle, game_status 01, PLAY after 2nd tick, ball_step follows 3rd tick by 1 cycle.
REQ-034 PLAY, lives=3: fall_down+strike_brick same cycle -> lives=2, score unchanged, bricks_left unchanged, SERVE, ball_reload pulse.
REQ-035 BRICK_TOTAL=2: two strike_brick pulses -> score=20, bricks_left=0, game_status=11, win=1; start_btn -> 00.
REQ-036 SCORE_W=4, score=14: strike_board, strike_brick -> score 15, then stays 15.
REQ-037 PAUSE: frame_tick, strike_brick, fall_down -> ball_step=0, counters unchanged, status 10; pause_btn -> 01.
REQ-038 rst asserted mid-PLAY with strike_brick same cycle -> next cycle all outputs at reset values, game_status=00.

Source files
------------

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control/status bundle between the game sequencer and its surroundings
interface game_sequencer_if #(
    parameter int SCORE_W = 16
);
    logic               start_btn;
    logic               pause_btn;
    logic               frame_tick;
    logic               fall_down;
    logic               strike_brick;
    logic               strike_board;
    logic [1:0]         game_status;
    logic               ball_step;
    logic               ball_reload;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic [7:0]         bricks_left;
    logic               win;
    logic [1:0]         speed_lvl;

    modport master (
        output start_btn, pause_btn, frame_tick, fall_down, strike_brick, strike_board,
        input  game_status, ball_step, ball_reload, score, lives, bricks_left, win, speed_lvl
    );

    modport slave (
        input  start_btn, pause_btn, frame_tick, fall_down, strike_brick, strike_board,
        output game_status, ball_step, ball_reload, score, lives, bricks_left, win, speed_lvl
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - breakout game state sequencer: serve, play, pause, scoring, lives
// Optional ball speed-up on every 8 bricks destroyed when GAME_SPEEDUP_EN is defined.
module game_sequencer #(
    parameter int LIVES_INIT  = 3,
    parameter int BRICK_TOTAL = 40,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.slave  gs
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_DELAY - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         status_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [7:0]         bricks_q, bricks_d;
    logic               win_q, win_d;
    logic               step_q, step_d;
    logic               reload_q, reload_d;

    function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] s,
                                                   input logic [3:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W-3){1'b0}}, inc};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [1:0] status_of(input logic [2:0] st);
        case (st)
            S_SERVE, S_PLAY: return 2'b01;
            S_PAUSE:         return 2'b10;
            S_OVER:          return 2'b11;
            default:         return 2'b00;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        lives_d  = lives_q;
        bricks_d = bricks_q;
        win_d    = win_q;
        reload_d = 1'b0;
        step_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gs.start_btn) begin
                    state_d  = S_SERVE;
                    lives_d  = 2'(LIVES_INIT);
                    score_d  = '0;
                    bricks_d = 8'(BRICK_TOTAL);
                    win_d    = 1'b0;
                    cnt_d    = 8'd0;
                    reload_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (gs.frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = S_PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // pause wins over any collision; collisions are mutually prioritised
                if (gs.pause_btn) begin
                    state_d = S_PAUSE;
                end else if (gs.fall_down) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = S_OVER;
                        win_d   = 1'b0;
                    end else begin
                        state_d  = S_SERVE;
                        cnt_d    = 8'd0;
                        reload_d = 1'b1;
                    end
                end else if (gs.strike_brick) begin
                    score_d  = add_sat(score_q, 4'd10);
                    bricks_d = bricks_q - 8'd1;
                    if (bricks_q == 8'd1) begin
                        state_d = S_OVER;
                        win_d   = 1'b1;
                    end
                end else if (gs.strike_board) begin
                    score_d = add_sat(score_q, 4'd1);
                end
            end
            S_PAUSE: begin
                if (gs.pause_btn)
                    state_d = S_PLAY;
            end
            S_OVER: begin
                if (gs.start_btn)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a tick that coincides with leaving PLAY must not advance the ball
        if (state_q == S_PLAY && state_d == S_PLAY && gs.frame_tick)
            step_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            status_q <= 2'b00;
            cnt_q    <= 8'd0;
            score_q  <= '0;
            lives_q  <= 2'd0;
            bricks_q <= 8'd0;
            win_q    <= 1'b0;
            step_q   <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_of(state_d);
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            bricks_q <= bricks_d;
            win_q    <= win_d;
            step_q   <= step_d;
            reload_q <= reload_d;
        end
    end

`ifdef GAME_SPEEDUP_EN
    logic [1:0] speed_q, speed_d;
    logic [7:0] destroyed;
    logic       brick_hit;

    always_comb begin
        speed_d   = speed_q;
        destroyed = 8'(BRICK_TOTAL) - bricks_d;
        brick_hit = (state_q == S_PLAY) && !gs.pause_btn && !gs.fall_down && gs.strike_brick;
        if (state_q == S_IDLE && gs.start_btn)
            speed_d = 2'd0;
        else if (brick_hit && destroyed[2:0] == 3'd0 && speed_q != 2'd3)
            speed_d = speed_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            speed_q <= 2'd0;
        else
            speed_q <= speed_d;
    end

    assign gs.speed_lvl = speed_q;
`else
    assign gs.speed_lvl = 2'b00;
`endif

    assign gs.game_status = status_q;
    assign gs.ball_step   = step_q;
    assign gs.ball_reload = reload_q;
    assign gs.score       = score_q;
    assign gs.lives       = lives_q;
    assign gs.bricks_left = bricks_q;
    assign gs.win         = win_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;
    localparam logic [5:0] START = 6'b100000;
    localparam logic [5:0] PAUSE = 6'b010000;
    localparam logic [5:0] TICK  = 6'b001000;
    localparam logic [5:0] FALL  = 6'b000100;
    localparam logic [5:0] BRICK = 6'b000010;
    localparam logic [5:0] BOARD = 6'b000001;
    localparam logic [5:0] NONE  = 6'b000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] in_a = '0;
    logic [5:0] in_b = '0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    game_sequencer_if #(.SCORE_W(16)) ifa ();
    game_sequencer_if #(.SCORE_W(4))  ifb ();

    assign {ifa.start_btn, ifa.pause_btn, ifa.frame_tick,
            ifa.fall_down, ifa.strike_brick, ifa.strike_board} = in_a;
    assign {ifb.start_btn, ifb.pause_btn, ifb.frame_tick,
            ifb.fall_down, ifb.strike_brick, ifb.strike_board} = in_b;

    game_sequencer #(.LIVES_INIT(3), .BRICK_TOTAL(2), .SERVE_DELAY(2), .SCORE_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .gs  (ifa)
    );

    game_sequencer #(.LIVES_INIT(3), .BRICK_TOTAL(3), .SERVE_DELAY(2), .SCORE_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .gs  (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // hold v for exactly one rising edge, return at the following falling edge
    task automatic cyc(input bit sel_b, input logic [5:0] v);
        @(negedge clk);
        if (sel_b) in_b = v;
        else       in_a = v;
        @(negedge clk);
        in_a = '0;
        in_b = '0;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, " status"}, 32'(ifa.game_status), 0);
        check({tag, " score"},  32'(ifa.score),       0);
        check({tag, " lives"},  32'(ifa.lives),       0);
        check({tag, " bricks"}, 32'(ifa.bricks_left), 0);
        check({tag, " win"},    32'(ifa.win),         0);
        check({tag, " step"},   32'(ifa.ball_step),   0);
        check({tag, " reload"}, 32'(ifa.ball_reload), 0);
        check({tag, " speed"},  32'(ifa.speed_lvl),   0);
    endtask

    initial begin
        rst = 1'b1;
        cyc(0, NONE);
        cyc(0, NONE);
        rst = 1'b0;
        check_a_reset("reset");

        // start and serve
        cyc(0, START);
        check("start status", 32'(ifa.game_status), 1);
        check("start reload", 32'(ifa.ball_reload), 1);
        check("start lives",  32'(ifa.lives),       3);
        check("start bricks", 32'(ifa.bricks_left), 2);
        check("start score",  32'(ifa.score),       0);
        cyc(0, NONE);
        check("reload one cycle", 32'(ifa.ball_reload), 0);
        cyc(0, BRICK);
        check("serve ignores brick", 32'(ifa.bricks_left), 2);
        cyc(0, TICK);
        check("serve tick1 step", 32'(ifa.ball_step), 0);
        cyc(0, TICK);
        check("serve tick2 status", 32'(ifa.game_status), 1);
        check("serve tick2 step",   32'(ifa.ball_step),   0);
        cyc(0, TICK);
        check("play tick step", 32'(ifa.ball_step), 1);
        cyc(0, NONE);
        check("step one cycle", 32'(ifa.ball_step), 0);

        // fall_down beats strike_brick
        cyc(0, FALL | BRICK);
        check("fall lives",  32'(ifa.lives),       2);
        check("fall score",  32'(ifa.score),       0);
        check("fall bricks", 32'(ifa.bricks_left), 2);
        check("fall reload", 32'(ifa.ball_reload), 1);
        check("fall status", 32'(ifa.game_status), 1);
        cyc(0, START);
        check("serve ignores start", 32'(ifa.game_status), 1);
        cyc(0, TICK);
        cyc(0, TICK);

        // pause freezes everything
        cyc(0, PAUSE);
        check("pause status", 32'(ifa.game_status), 2);
        cyc(0, TICK | BRICK | FALL);
        check("pause step",   32'(ifa.ball_step),   0);
        check("pause score",  32'(ifa.score),       0);
        check("pause lives",  32'(ifa.lives),       2);
        check("pause bricks", 32'(ifa.bricks_left), 2);
        check("pause status hold", 32'(ifa.game_status), 2);
        cyc(0, START);
        check("pause ignores start", 32'(ifa.game_status), 2);
        cyc(0, PAUSE);
        check("unpause status", 32'(ifa.game_status), 1);
        cyc(0, PAUSE | BRICK);
        check("pause over brick status", 32'(ifa.game_status), 2);
        check("pause over brick bricks", 32'(ifa.bricks_left), 2);
        cyc(0, PAUSE);

        // clear both bricks; board discarded under brick
        cyc(0, BRICK);
        check("brick1 score",  32'(ifa.score),       10);
        check("brick1 bricks", 32'(ifa.bricks_left), 1);
        cyc(0, BRICK | BOARD);
        check("brick2 score",  32'(ifa.score),       20);
        check("brick2 bricks", 32'(ifa.bricks_left), 0);
        check("win status",    32'(ifa.game_status), 3);
        check("win flag",      32'(ifa.win),         1);
        cyc(0, TICK | FALL | BRICK | PAUSE);
        check("over hold score", 32'(ifa.score),       20);
        check("over hold lives", 32'(ifa.lives),       2);
        check("over hold win",   32'(ifa.win),         1);
        check("over hold status",32'(ifa.game_status), 3);
        check("over step",       32'(ifa.ball_step),   0);
        cyc(0, START);
        check("over to idle", 32'(ifa.game_status), 0);

        // new game, lose all lives
        cyc(0, START);
        check("restart score", 32'(ifa.score),       0);
        check("restart lives", 32'(ifa.lives),       3);
        check("restart bricks",32'(ifa.bricks_left), 2);
        check("restart win",   32'(ifa.win),         0);
        cyc(0, TICK);
        cyc(0, TICK);
        for (int i = 0; i < 3; i++) begin
            cyc(0, FALL);
            check("lose lives", 32'(ifa.lives), 32'(2 - i));
            if (i < 2) begin
                cyc(0, TICK);
                cyc(0, TICK);
            end
        end
        check("lost status", 32'(ifa.game_status), 3);
        check("lost win",    32'(ifa.win),         0);
        cyc(0, START);
        check("lost to idle", 32'(ifa.game_status), 0);

        // reset mid-play overrides a brick hit
        cyc(0, START);
        cyc(0, TICK);
        cyc(0, TICK);
        cyc(0, BOARD);
        check("board score", 32'(ifa.score), 1);
        rst = 1'b1;
        cyc(0, BRICK);
        rst = 1'b0;
        check_a_reset("midplay reset");

        // score saturation on the narrow-score instance
        cyc(1, START);
        cyc(1, TICK);
        cyc(1, TICK);
        cyc(1, BRICK);
        check("b brick score", 32'(ifb.score), 10);
        for (int i = 0; i < 4; i++) cyc(1, BOARD);
        check("b score 14", 32'(ifb.score), 14);
        cyc(1, BOARD);
        check("b score 15", 32'(ifb.score), 15);
        cyc(1, BRICK);
        check("b sat brick score",  32'(ifb.score),       15);
        check("b sat brick bricks", 32'(ifb.bricks_left), 1);
        cyc(1, BOARD);
        check("b sat board score", 32'(ifb.score), 15);
        check("b status", 32'(ifb.game_status), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
